uart_tx_fifo: RTL

//  Parametrised UART transmitter, successor to the single-byte 8N1 TX.

---
 rtl/uart_tx_fifo.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a configurable frame and a queue in front of it.
// A producer pushes words through a valid/ready handshake. Queued words go out on tx_out
// back-to-back, with the stop bits of one frame followed directly by the start bit of the next.
// tx_out and tx_busy are registered and lag the FSM state by one clock, so they stay aligned.
module uart_tx_fifo #(
  parameter int CLK_FRQ    = 27000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DATA_BITS-1:0]              tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              tx_out,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int CYCLE = CLK_FRQ / BAUD_RATE;
  localparam int CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  // Bad parameter combinations are rejected while the design is being built.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (CYCLE < 2) begin : g_bad_cycle
    $error("uart_tx_fifo: CLK_FRQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Parity bit for a word: odd parity when PARITY is 1, even parity otherwise.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      return ~^d;
    end else begin
      return ^d;
    end
  endfunction

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_ready;
  logic [LW-1:0]        w_level_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_ne;
  logic [DATA_BITS-1:0] w_head;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cyc_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx_out;
  logic                 r_busy;
  logic                 w_tx_nxt;
  logic                 w_bit_end;

  // A full queue accepts nothing, even when a pop happens on the same edge.
  assign w_push    = tx_valid && r_ready;
  assign w_fifo_ne = (r_level != {LW{1'b0}});
  assign w_head    = r_mem[r_rd_ptr];
  assign w_bit_end = (r_cyc_cnt == CW'(CYCLE - 1));

  assign tx_ready   = r_ready;
  assign tx_out     = r_tx_out;
  assign tx_busy    = r_busy;
  assign fifo_level = r_level;

  // Write queued words into storage; the contents need no reset because the pointers and level are reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // Next occupancy: a push and a pop on the same edge leave the level unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Queue pointers, level and ready flag. The pointers wrap naturally because the depth is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LW'(FIFO_DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, the pop request, and the line level driven by the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_fifo_ne) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_end && (r_bit_cnt == 4'(DATA_BITS - 1))) begin
          w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PAR: begin
        w_tx_nxt = r_par;
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PAR;
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end && (r_bit_cnt == 4'(STOP_BITS - 1))) begin
          if (w_fifo_ne) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bit timing counters, shift register and parity capture. bit_cnt restarts at every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc_cnt <= {CW{1'b0}};
      r_bit_cnt <= 4'd0;
      r_shift   <= {DATA_BITS{1'b0}};
      r_par     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || w_bit_end) begin
        r_cyc_cnt <= {CW{1'b0}};
      end else begin
        r_cyc_cnt <= r_cyc_cnt + CW'(1);
      end
      if (r_state != w_state_nxt) begin
        r_bit_cnt <= 4'd0;
      end else if (w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= calc_parity(w_head);
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  // Registered line and busy flag. Reset forces the line high at once and abandons any frame in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_out <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_tx_out <= w_tx_nxt;
      r_busy   <= (r_state != S_IDLE) || w_fifo_ne;
    end
  end

endmodule
